// File: rtl/ccd_pixel_sink_pkg.sv
// Shared constants, FIFO entry width and state encodings for ccd_pixel_sink.
// CCD_PIXEL_SINK_HEADER_EN adds an SOF bit to each FIFO entry and the frame-header states.
package ccd_pixel_sink_pkg;

  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;

`ifdef CCD_PIXEL_SINK_HEADER_EN
  localparam int FIFO_W = 17;
`else
  localparam int FIFO_W = 16;
`endif

  typedef enum logic {
    CAP_WAIT,
    CAP_ACK
  } cap_state_t;

`ifdef CCD_PIXEL_SINK_HEADER_EN
  typedef enum logic [2:0] {
    SER_IDLE,
    SER_LO,
    SER_HI,
    SER_H0,
    SER_H1,
    SER_H2,
    SER_H3
  } ser_state_t;
`else
  typedef enum logic [1:0] {
    SER_IDLE,
    SER_LO,
    SER_HI
  } ser_state_t;
`endif

endpackage

// File: rtl/pixel_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through read data and an occupancy count.
module pixel_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/ccd_pixel_sink.sv
// Captures readout pixel words into a FIFO and serialises them little-endian onto a byte stream.
// CCD_PIXEL_SINK_HEADER_EN prefixes each frame's first word with a 4-byte header.
//
// state     | meaning
// CAP_WAIT  | waiting for synchronised avail; blocks while FIFO full
// CAP_ACK   | word stored, holding accept until avail drops
// SER_IDLE  | nothing to send
// SER_LO    | offering low byte of held word
// SER_HI    | offering high byte of held word
// SER_H0-3  | offering header bytes A5, 5A, frame lo, frame hi
module ccd_pixel_sink
  import ccd_pixel_sink_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   pix_data,
  input  logic                          pix_avail,
  output logic                          pix_accept,
  input  logic                          ccd_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [15:0]                   frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [SYNC_STAGES-1:0] avail_sync_q, busy_sync_q;
  logic avail_s, busy_s, busy_prev_q, busy_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_sync_q <= '0;
      busy_sync_q  <= '0;
      busy_prev_q  <= 1'b0;
    end else begin
      avail_sync_q <= {avail_sync_q[SYNC_STAGES-2:0], pix_avail};
      busy_sync_q  <= {busy_sync_q[SYNC_STAGES-2:0], ccd_busy};
      busy_prev_q  <= busy_s;
    end
  end

  assign avail_s   = avail_sync_q[SYNC_STAGES-1];
  assign busy_s    = busy_sync_q[SYNC_STAGES-1];
  assign busy_rise = busy_s & ~busy_prev_q;

  logic              push, pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  cap_state_t  cap_state_q, cap_state_d;
  logic        pix_accept_q, pix_accept_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        sof_q, sof_d;

  always_comb begin
    cap_state_d  = cap_state_q;
    pix_accept_d = pix_accept_q;
    push         = 1'b0;
    case (cap_state_q)
      CAP_WAIT: if (avail_s && !fifo_full) begin
        push         = 1'b1;
        cap_state_d  = CAP_ACK;
        pix_accept_d = 1'b1;
      end
      CAP_ACK: if (!avail_s) begin
        cap_state_d  = CAP_WAIT;
        pix_accept_d = 1'b0;
      end
      default: cap_state_d = CAP_WAIT;
    endcase
    frame_cnt_d = frame_cnt_q + 16'(busy_rise);
    // A frame start landing on the same cycle as a write arms SOF for the following word.
    sof_d       = busy_rise | (sof_q & ~push);
  end

`ifdef CCD_PIXEL_SINK_HEADER_EN
  assign fifo_wdata = {sof_q, pix_data};
`else
  assign fifo_wdata = pix_data;
`endif

  pixel_word_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(fifo_wdata),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  ser_state_t  ser_q, ser_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        load;
`ifdef CCD_PIXEL_SINK_HEADER_EN
  logic [15:0] hdr_cnt_q, hdr_cnt_d;
`endif

  always_comb begin
    ser_d  = ser_q;
    hold_d = hold_q;
    pop    = 1'b0;
    load   = 1'b0;
`ifdef CCD_PIXEL_SINK_HEADER_EN
    hdr_cnt_d = hdr_cnt_q;
`endif
    case (ser_q)
      SER_IDLE: load = !fifo_empty;
      SER_LO:   if (tx_ready) ser_d = SER_HI;
      SER_HI:   if (tx_ready) begin
        if (!fifo_empty) load = 1'b1;
        else             ser_d = SER_IDLE;
      end
`ifdef CCD_PIXEL_SINK_HEADER_EN
      SER_H0:   if (tx_ready) ser_d = SER_H1;
      SER_H1:   if (tx_ready) ser_d = SER_H2;
      SER_H2:   if (tx_ready) ser_d = SER_H3;
      SER_H3:   if (tx_ready) ser_d = SER_LO;
`endif
      default:  ser_d = SER_IDLE;
    endcase
    if (load) begin
      pop    = 1'b1;
      hold_d = fifo_rdata[15:0];
`ifdef CCD_PIXEL_SINK_HEADER_EN
      if (fifo_rdata[16]) begin
        ser_d     = SER_H0;
        hdr_cnt_d = frame_cnt_q;
      end else begin
        ser_d = SER_LO;
      end
`else
      ser_d = SER_LO;
`endif
    end
    // Outputs are decoded from the next state so they register alongside it.
    tx_valid_d = (ser_d != SER_IDLE);
    case (ser_d)
      SER_LO:  tx_data_d = hold_d[7:0];
      SER_HI:  tx_data_d = hold_d[15:8];
`ifdef CCD_PIXEL_SINK_HEADER_EN
      SER_H0:  tx_data_d = HDR_SYNC0;
      SER_H1:  tx_data_d = HDR_SYNC1;
      SER_H2:  tx_data_d = hdr_cnt_d[7:0];
      SER_H3:  tx_data_d = hdr_cnt_d[15:8];
`endif
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_q  <= CAP_WAIT;
      pix_accept_q <= 1'b0;
      frame_cnt_q  <= '0;
      sof_q        <= 1'b0;
      ser_q        <= SER_IDLE;
      hold_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
`ifdef CCD_PIXEL_SINK_HEADER_EN
      hdr_cnt_q    <= '0;
`endif
    end else begin
      cap_state_q  <= cap_state_d;
      pix_accept_q <= pix_accept_d;
      frame_cnt_q  <= frame_cnt_d;
      sof_q        <= sof_d;
      ser_q        <= ser_d;
      hold_q       <= hold_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
`ifdef CCD_PIXEL_SINK_HEADER_EN
      hdr_cnt_q    <= hdr_cnt_d;
`endif
    end
  end

  assign pix_accept = pix_accept_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
